// File: rtl/fifo_stream_pkg.sv
// ============================================================================
// Module   : fifo_stream_pkg
// Purpose  : Shared types and FIFO word layout helpers for the stream packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_stream_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // FIFO word is {last, keep[ratio-1:0], data[ratio*in_w-1:0]}
   function automatic int f_word_width(input int in_w, input int ratio);
      return in_w * ratio + ratio + 1;
   endfunction

   function automatic int f_keep_lsb(input int in_w, input int ratio);
      return in_w * ratio;
   endfunction

   function automatic int f_last_bit(input int in_w, input int ratio);
      return in_w * ratio + ratio;
   endfunction

   localparam int c_DEF_IN_WIDTH = 8;
   localparam int c_DEF_RATIO    = 4;
   localparam int c_DEF_KEEP_LSB = f_keep_lsb(c_DEF_IN_WIDTH, c_DEF_RATIO);
   localparam int c_DEF_LAST_BIT = f_last_bit(c_DEF_IN_WIDTH, c_DEF_RATIO);

endpackage

`default_nettype wire

// File: rtl/fifo_stream_packer.sv
// ============================================================================
// Module   : fifo_stream_packer
// Purpose  : Packs a narrow framed byte stream into keep/last-tagged FIFO words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_packer
   import fifo_stream_pkg::*;
#(
   parameter int G_IN_WIDTH  = 8,
   parameter int G_RATIO     = 4,
   parameter int G_CNT_WIDTH = 16
) (
   input  logic                                          i_clkW,
   input  logic                                          i_arstnW,
   input  logic                                          i_valid,
   output logic                                          o_ready,
   input  logic [G_IN_WIDTH-1:0]                         i_data,
   input  logic                                          i_last,
   input  logic                                          i_flush,
   output logic                                          o_wren,
   output logic [f_word_width(G_IN_WIDTH, G_RATIO)-1:0]  o_dataW,
   input  logic                                          i_full,
   output logic [G_CNT_WIDTH-1:0]                        o_words,
   output logic [G_CNT_WIDTH-1:0]                        o_frames
);

   localparam int c_DATA_W   = G_IN_WIDTH * G_RATIO;
   localparam int c_WORD_W   = f_word_width(G_IN_WIDTH, G_RATIO);
   localparam int c_LAST_BIT = f_last_bit(G_IN_WIDTH, G_RATIO);
   localparam int c_LANE_W   = $clog2(G_RATIO);
   localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(G_RATIO - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_DATA_W-1:0]     r_acc_data;
   logic [c_DATA_W-1:0]     w_acc_data_nxt;
   logic [G_RATIO-1:0]      r_acc_keep;
   logic [G_RATIO-1:0]      w_acc_keep_nxt;
   logic                    r_acc_last;
   logic                    w_acc_last_nxt;
   logic [c_LANE_W-1:0]     r_lane;
   logic [c_LANE_W-1:0]     w_lane_nxt;
   logic                    r_wren;
   logic                    w_wren_nxt;
   logic [c_WORD_W-1:0]     r_dataW;
   logic [c_WORD_W-1:0]     w_dataW_nxt;
   logic [G_CNT_WIDTH-1:0]  r_words;
   logic [G_CNT_WIDTH-1:0]  r_frames;

   logic                    w_take;
   logic                    w_accept;
   logic                    w_slot_free;
   logic                    w_complete;
   logic [c_DATA_W-1:0]     w_ins_data;
   logic [G_RATIO-1:0]      w_ins_keep;
   logic                    w_ins_last;

   assign w_take      = i_valid && (r_state == FILL);
   assign w_accept    = r_wren && !i_full;
   assign w_slot_free = !r_wren || w_accept;

   // Accumulator contents as they would be after including this cycle's beat
   always_comb begin
      w_ins_data = r_acc_data;
      w_ins_keep = r_acc_keep;
      for (int k = 0; k < G_RATIO; k++) begin
         if (w_take && (r_lane == c_LANE_W'(k))) begin
            w_ins_data[k*G_IN_WIDTH +: G_IN_WIDTH] = i_data;
            w_ins_keep[k]                          = 1'b1;
         end
      end
      w_ins_last = w_take && i_last;
      w_complete = (r_state == FILL) &&
                   ((w_take && ((r_lane == c_LAST_LANE) || i_last)) ||
                    (i_flush && (|w_ins_keep)));
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_acc_data_nxt = r_acc_data;
      w_acc_keep_nxt = r_acc_keep;
      w_acc_last_nxt = r_acc_last;
      w_lane_nxt     = r_lane;
      w_wren_nxt     = r_wren && !w_accept;
      w_dataW_nxt    = r_dataW;
      o_ready        = (r_state == FILL);
      unique case (r_state)
         FILL: begin
            if (w_complete) begin
               w_lane_nxt = '0;
               if (w_slot_free) begin
                  w_dataW_nxt    = {w_ins_last, w_ins_keep, w_ins_data};
                  w_wren_nxt     = 1'b1;
                  w_acc_data_nxt = '0;
                  w_acc_keep_nxt = '0;
                  w_acc_last_nxt = 1'b0;
               end else begin
                  w_acc_data_nxt = w_ins_data;
                  w_acc_keep_nxt = w_ins_keep;
                  w_acc_last_nxt = w_ins_last;
                  w_state_nxt    = HOLD;
               end
            end else if (w_take) begin
               w_acc_data_nxt = w_ins_data;
               w_acc_keep_nxt = w_ins_keep;
               w_lane_nxt     = r_lane + c_LANE_W'(1);
            end
         end
         HOLD: begin
            if (w_accept) begin
               w_dataW_nxt    = {r_acc_last, r_acc_keep, r_acc_data};
               w_wren_nxt     = 1'b1;
               w_acc_data_nxt = '0;
               w_acc_keep_nxt = '0;
               w_acc_last_nxt = 1'b0;
               w_state_nxt    = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge i_clkW or negedge i_arstnW) begin
      if (!i_arstnW) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clkW or negedge i_arstnW) begin
      if (!i_arstnW) begin
         r_acc_data <= '0;
         r_acc_keep <= '0;
         r_acc_last <= 1'b0;
         r_lane     <= '0;
         r_wren     <= 1'b0;
         r_dataW    <= '0;
      end else begin
         r_acc_data <= w_acc_data_nxt;
         r_acc_keep <= w_acc_keep_nxt;
         r_acc_last <= w_acc_last_nxt;
         r_lane     <= w_lane_nxt;
         r_wren     <= w_wren_nxt;
         r_dataW    <= w_dataW_nxt;
      end
   end

   always_ff @(posedge i_clkW or negedge i_arstnW) begin
      if (!i_arstnW) begin
         r_words  <= '0;
         r_frames <= '0;
      end else if (w_accept) begin
         r_words <= r_words + G_CNT_WIDTH'(1);
         if (r_dataW[c_LAST_BIT]) begin
            r_frames <= r_frames + G_CNT_WIDTH'(1);
         end
      end
   end

   assign o_wren   = r_wren;
   assign o_dataW  = r_dataW;
   assign o_words  = r_words;
   assign o_frames = r_frames;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_packer.sv
// ============================================================================
// Module   : tb_fifo_stream_packer
// Purpose  : Directed self-checking bench for the FIFO stream packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_packer;

   localparam int c_W = 37;

   logic             i_clkW;
   logic             i_arstnW;
   logic             i_valid;
   logic             o_ready;
   logic [7:0]       i_data;
   logic             i_last;
   logic             i_flush;
   logic             o_wren;
   logic [c_W-1:0]   o_dataW;
   logic             i_full;
   logic [15:0]      o_words;
   logic [15:0]      o_frames;

   int               checks = 0;
   int               errors = 0;
   int               cycle  = 0;
   logic [c_W-1:0]   wq[$];
   int               wt[$];

   fifo_stream_packer dut (
      .i_clkW   (i_clkW),
      .i_arstnW (i_arstnW),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_data   (i_data),
      .i_last   (i_last),
      .i_flush  (i_flush),
      .o_wren   (o_wren),
      .o_dataW  (o_dataW),
      .i_full   (i_full),
      .o_words  (o_words),
      .o_frames (o_frames)
   );

   initial i_clkW = 1'b0;
   always #5 i_clkW = ~i_clkW;

   // Record every word the FIFO would accept, with its cycle number
   always @(posedge i_clkW) begin
      cycle <= cycle + 1;
      if (i_arstnW && o_wren && !i_full) begin
         wq.push_back(o_dataW);
         wt.push_back(cycle);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clkW);
      #1;
   endtask

   // Present one beat and wait (bounded) until it is taken
   task automatic send(input logic [7:0] d, input logic l);
      int budget;
      budget  = 50;
      i_valid = 1'b1;
      i_data  = d;
      i_last  = l;
      while (!o_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL send_timeout observed=not_ready expected=ready");
      end
      tick();
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   initial begin
      logic [c_W-1:0] exp_w;
      int drops;

      i_arstnW = 1'b0;
      i_valid  = 1'b0;
      i_data   = '0;
      i_last   = 1'b0;
      i_flush  = 1'b0;
      i_full   = 1'b0;
      repeat (3) tick();
      i_arstnW = 1'b1;
      tick();

      chk("rst_ready",  o_ready,  1'b1);
      chk("rst_wren",   o_wren,   1'b0);
      chk("rst_dataW",  o_dataW,  37'h0);
      chk("rst_words",  o_words,  16'd0);
      chk("rst_frames", o_frames, 16'd0);

      // Full 4-beat frame
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      chk("t1_no_early_wren", o_wren, 1'b0);
      send(8'h44, 1'b1);
      chk("t1_wren",  o_wren,  1'b1);
      chk("t1_dataW", o_dataW, 37'h1F44332211);
      tick();
      chk("t1_wren_pulse", o_wren,   1'b0);
      chk("t1_words",      o_words,  16'd1);
      chk("t1_frames",     o_frames, 16'd1);

      // Short frame, partial keep
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      chk("t2_wren",  o_wren,  1'b1);
      chk("t2_dataW", o_dataW, 37'h130000BBAA);
      tick();
      chk("t2_words",  o_words,  16'd2);
      chk("t2_frames", o_frames, 16'd2);

      // Partial word flushed without last
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("t3_wren",  o_wren,  1'b1);
      chk("t3_dataW", o_dataW, 37'h0700030201);
      tick();
      chk("t3_words",  o_words,  16'd3);
      chk("t3_frames", o_frames, 16'd2);

      // Flush with empty accumulator does nothing
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("t3_empty_flush_wren", o_wren, 1'b0);

      // Back-pressure: slot full then HOLD
      i_full = 1'b1;
      for (int i = 1; i <= 8; i++) send(8'(8'h40 + i), 1'b0);
      chk("t4_ready_low", o_ready, 1'b0);
      chk("t4_wren_held", o_wren,  1'b1);
      chk("t4_slot_w1",   o_dataW, 37'h0F44434241);
      repeat (3) tick();
      chk("t4_ready_still_low", o_ready, 1'b0);
      chk("t4_slot_stable",     o_dataW, 37'h0F44434241);
      chk("t4_words_frozen",    o_words, 16'd3);
      i_valid = 1'b1;
      i_data  = 8'h49;
      i_full  = 1'b0;
      tick();
      chk("t4_ready_back", o_ready, 1'b1);
      chk("t4_wren_w2",    o_wren,  1'b1);
      chk("t4_slot_w2",    o_dataW, 37'h0F48474645);
      chk("t4_words_w1",   o_words, 16'd4);
      send(8'h49, 1'b0);
      send(8'h4A, 1'b0);
      send(8'h4B, 1'b0);
      send(8'h4C, 1'b1);
      chk("t4_slot_w3", o_dataW, 37'h1F4C4B4A49);
      tick();
      chk("t4_words",  o_words,  16'd6);
      chk("t4_frames", o_frames, 16'd3);

      // Continuous streaming, no bubbles
      wq.delete();
      wt.delete();
      drops = 0;
      for (int i = 0; i < 64; i++) begin
         i_valid = 1'b1;
         i_data  = 8'(i);
         if (!o_ready) drops++;
         tick();
      end
      i_valid = 1'b0;
      repeat (3) tick();
      chk("t5_ready_drops", drops,     0);
      chk("t5_nwrites",     wq.size(), 16);
      chk("t5_words",       o_words,   16'd22);
      if (wq.size() == 16) begin
         for (int j = 0; j < 16; j++) begin
            exp_w = {1'b0, 4'hF, 8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            chk($sformatf("t5_word%0d", j), wq[j], exp_w);
            if (j > 0) chk($sformatf("t5_gap%0d", j), wt[j] - wt[j-1], 4);
         end
      end

      // Reset while a word sits in HOLD
      i_full = 1'b1;
      for (int i = 0; i < 8; i++) send(8'(8'h80 + i), 1'b0);
      chk("t6_in_hold", o_ready, 1'b0);
      i_arstnW = 1'b0;
      #1;
      chk("t6_rst_wren",   o_wren,   1'b0);
      chk("t6_rst_words",  o_words,  16'd0);
      chk("t6_rst_frames", o_frames, 16'd0);
      chk("t6_rst_ready",  o_ready,  1'b1);
      tick();
      i_full   = 1'b0;
      i_arstnW = 1'b1;
      wq.delete();
      repeat (4) tick();
      chk("t6_no_stale_write", wq.size(), 0);
      chk("t6_wren_idle",      o_wren,    1'b0);
      chk("t6_words_idle",     o_words,   16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_stream_packer.md
Name: fifo_stream_packer

Overview:
- Write-side producer for the dual-clock FIFO. Runs entirely in the write clock domain.
- Accepts a narrow valid/ready byte stream with frame markers and packs g_ratio beats into one FIFO word.
- Each FIFO word carries a per-lane keep mask and a last flag.
- Drives the FIFO write port (wren/dataW) and honours the FIFO's registered full flag.

Parameters:
- g_in_width, 8: width of one input beat (lane).
- g_ratio, 4: lanes per FIFO word; must be a power of 2 and ≥2.
- g_cnt_width, 16: width of the status counters.

Ports:
- i_clkW  in  1  write-domain clock.
- i_arstnW  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  packer can take a beat.
- i_data  in  g_in_width  input beat.
- i_last  in  1  beat ends a frame.
- i_flush  in  1  emit the partial word without last.
- o_wren  out  1  FIFO write request.
- o_dataW  out  g_ratio*g_in_width+g_ratio+1  FIFO word, packed as {last, keep[g_ratio-1:0], data}.
- i_full  in  1  FIFO full flag, registered in the FIFO in the i_clkW domain.
- o_words  out  g_cnt_width  count of FIFO words accepted.
- o_frames  out  g_cnt_width  count of words with last=1 accepted.

Behaviour:
- **Reset values:** o_ready=1, o_wren=0, o_dataW=0, o_words=0, o_frames=0, lane index=0, accumulator and keep cleared. Reset mid-operation discards any partial or pending word; nothing is written after reset asserts.
- **Input handshake:** a beat is taken at a posedge where i_valid && o_ready. The producer must hold i_data/i_last stable while i_valid && !o_ready.
- **Lane packing:**
  - Beat k of a word goes to data[k*g_in_width +: g_in_width] and sets keep[k]. Lane 0 is at the LSBs.
  - Unused lanes are driven 0 and have keep=0.
- **Word complete** when any of these holds:
  - the accepted beat fills lane g_ratio-1;
  - the accepted beat has i_last=1 (word last=1);
  - i_flush=1 while the accumulator holds ≥1 lane (last=0). i_flush with an empty accumulator and no beat is a no-op.
- **Flush with beat:** i_flush and an accepted beat in the same cycle → the beat is included first, then the word completes. last follows i_last.
- **Output slot:** one register driving o_wren/o_dataW.
  - FIFO accepts the word at a posedge where o_wren && !i_full. o_wren and o_dataW stay stable until accepted.
  - While i_full=1, o_wren stays high and the word is retried every cycle.
- **FSM, state FILL:**
  - o_ready=1.
  - On word complete: if the slot is empty or accepted this cycle, load the slot at the same edge. o_wren rises 1 cycle after the completing beat. Accumulator clears, lane index returns to 0.
  - Otherwise go to HOLD.
- **FSM, state HOLD:**
  - o_ready=0; the completed word is held in the accumulator.
  - At the edge where the slot is accepted, the accumulator moves into the slot, the state returns to FILL, and o_ready=1 next cycle.
- **Back-to-back:** with i_full=0 and i_valid=1 continuously, throughput is one FIFO word per g_ratio cycles with no bubbles. o_wren pulses 1 cycle per word.
- **Counters:**
  - o_words increments on each FIFO acceptance.
  - o_frames increments on each accepted word with last=1.
  - Both wrap modulo 2^g_cnt_width.
- **Lane index:** log2(g_ratio) bits. It never exceeds g_ratio-1 and is reset to 0 on every word complete.

Decomposition:
- Package fifo_stream_pkg:
  - state enum {FILL, HOLD};
  - function for the FIFO word width from g_in_width/g_ratio;
  - localparam offsets for the keep and last fields.
- No sub-module. The accumulator, slot and FSM live in one module; the parent instantiates the packer next to the FIFO and ties o_wren/o_dataW/i_full.

Test Plan (defaults, word width 37):
- Reset, then 4 beats 0x11,0x22,0x33,0x44 with last on the 4th, i_full=0 → one write with o_dataW={1,4'hF,32'h44332211} on the cycle after beat 4; o_words=1, o_frames=1.
- 2 beats 0xAA,0xBB with last on 2nd → o_dataW={1,4'h3,32'h0000BBAA}; next frame starts at lane 0.
- 3 beats then a lone i_flush pulse → o_dataW={0,4'h7,data}; o_frames unchanged, o_words+1.
- Hold i_full=1, stream 12 beats continuously → first word held on o_wren, second in HOLD, o_ready=0 after beat 8. Release i_full → 2 writes in order, o_ready returns, all 12 beats appear unmodified.
- Continuous 64 beats, i_full=0 → exactly 16 writes, one every 4 cycles, no o_ready deassertion.
- Assert i_arstnW low while HOLD with a pending word → o_wren=0 immediately, counters=0, no stale word written after release.
